// File: rtl/cpu_instrmem_loader.sv
`default_nettype none
// ==========================================================================
// cpu_instrmem_loader : writes 64-bit program beats into instruction memory
// as little-endian 32-bit words and holds the CPU in reset until complete.
// Rev 1.0
// ==========================================================================
module cpu_instrmem_loader #(
  parameter int MEM_BYTES = 65536,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-2:0] word_count,
  input  logic [63:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wrt_en,
  output logic [31:0]       mem_wrt_data,
  output logic              mem_sel,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WR_LO = 3'd2;
  localparam logic [2:0] S_WR_HI = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [ADDR_W+1:0] MEM_END   = (ADDR_W+2)'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
  localparam logic [ADDR_W-2:0] REM_ONE   = (ADDR_W-1)'(1);

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W-2:0] rem, rem_nxt;
  logic [63:0]       beat, beat_nxt;
  logic [ADDR_W-1:0] base_aligned;
  logic [ADDR_W+1:0] end_byte;
  logic              busy_nxt;
  logic              unused_lsbs;

  assign base_aligned = {base_addr[ADDR_W-1:2], 2'b00};
  assign unused_lsbs  = ^base_addr[1:0];
  // Two spare bits keep the end-of-image sum from wrapping for any count.
  assign end_byte     = {2'b00, base_aligned} + {1'b0, word_count, 2'b00};

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    rem_nxt   = rem;
    beat_nxt  = beat;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          addr_nxt = base_aligned;
          rem_nxt  = word_count;
          if (end_byte > MEM_END)
            state_nxt = S_ERR;
          else if (word_count == '0)
            state_nxt = S_DONE;
          else
            state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (in_valid && in_ready) begin
          beat_nxt  = in_data;
          state_nxt = S_WR_LO;
        end
      end
      S_WR_LO, S_WR_HI: begin
        // The word on the port this cycle lands regardless of abort.
        rem_nxt = rem - REM_ONE;
        if (rem != REM_ONE)
          addr_nxt = addr + ADDR_STEP;
        if (abort)
          state_nxt = S_IDLE;
        else if (rem == REM_ONE)
          state_nxt = S_DONE;
        else if (state == S_WR_LO)
          state_nxt = S_WR_HI;
        else
          state_nxt = S_FILL;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt == S_FILL) || (state_nxt == S_WR_LO) ||
                    (state_nxt == S_WR_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      addr         <= '0;
      rem          <= '0;
      beat         <= '0;
      in_ready     <= 1'b0;
      mem_wrt_en   <= 1'b0;
      mem_wrt_data <= '0;
      mem_sel      <= 1'b0;
      cpu_rst_n    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      rem        <= rem_nxt;
      beat       <= beat_nxt;
      in_ready   <= (state_nxt == S_FILL);
      mem_wrt_en <= (state_nxt == S_WR_LO) || (state_nxt == S_WR_HI);
      if (state_nxt == S_WR_LO)
        mem_wrt_data <= beat_nxt[31:0];
      else if (state_nxt == S_WR_HI)
        mem_wrt_data <= beat_nxt[63:32];
      mem_sel    <= busy_nxt;
      busy       <= busy_nxt;
      cpu_rst_n  <= (state_nxt == S_DONE);
      done       <= (state_nxt == S_DONE);
      err        <= (state_nxt == S_ERR);
    end
  end

  assign mem_addr = addr;

endmodule
`default_nettype wire

// File: tb/tb_cpu_instrmem_loader.sv
`default_nettype none
// Directed bench for cpu_instrmem_loader: word-level write scoreboard built
// from the load parameters, plus status checks where each load resolves.
module tb_cpu_instrmem_loader;

  logic        clk, rst_n, start, abort, in_valid;
  logic [15:0] base_addr;
  logic [14:0] word_count;
  logic [63:0] in_data;
  logic        in_ready, mem_wrt_en, mem_sel, cpu_rst_n, busy, done, err;
  logic [15:0] mem_addr;
  logic [31:0] mem_wrt_data;

  int          nvec = 0;
  int          nfail = 0;
  int          wr_count = 0;
  logic [15:0] last_addr = '0;
  logic [47:0] exp_q[$];
  logic [63:0] beats[$];

  cpu_instrmem_loader #(.MEM_BYTES(65536), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wrt_en(mem_wrt_en), .mem_wrt_data(mem_wrt_data),
    .mem_sel(mem_sel), .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: image words land in order at consecutive aligned addresses.
  function automatic bit model_range_err(input logic [15:0] base, input int n);
    return (int'(base & 16'hFFFC) + 4 * n) > 65536;
  endfunction

  task automatic expect_words(input logic [15:0] base, input int n);
    logic [15:0] a;
    logic [63:0] bt;
    a = base & 16'hFFFC;
    for (int k = 0; k < n; k++) begin
      bt = beats[k / 2];
      exp_q.push_back({a + 16'(4 * k), (k % 2 == 1) ? bt[63:32] : bt[31:0]});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_wrt_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                 mem_addr, mem_wrt_data);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e[47:32]);
        chk("wr_data", mem_wrt_data, e[31:0]);
        chk("wr_sel", mem_sel, 1);
      end
      wr_count++;
      last_addr = mem_addr;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wrt_en"}, mem_wrt_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wrt_data, 0);
    chk({tag, "_sel"}, mem_sel, 0);
    chk({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic do_start(input logic [15:0] b, input int n);
    @(negedge clk);
    base_addr  = b;
    word_count = 15'(n);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Offers beats[0..nbeats-1]; optionally idles for gap_len ready cycles
  // once gap_after beats have been taken. Returns in the first write cycle
  // of the final beat.
  task automatic feed(input int nbeats, input int gap_after, input int gap_len);
    int i = 0;
    int guard = 0;
    int gap_left = gap_len;
    bit gap_on = 0;
    while (i < nbeats && guard < 200) begin
      @(negedge clk);
      guard++;
      if (i == gap_after && gap_left > 0) begin
        in_valid = 1'b0;
        if (in_ready || gap_on) begin
          gap_on = 1;
          chk("bp_ready_held", in_ready, 1);
          chk("bp_no_write", mem_wrt_en, 0);
          chk("bp_addr", mem_addr, exp_q[0][47:32]);
          gap_left--;
        end
        continue;
      end
      in_valid = 1'b1;
      in_data  = beats[i];
      if (in_ready) i++;
    end
    if (i < nbeats) begin
      nvec++;
      nfail++;
      $display("FAIL feed_timeout: accepted %0d beats, expected %0d", i, nbeats);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_latency"}, n, exp_cycles);
    chk({name, "_cpu_rst_n"}, cpu_rst_n, 1);
    chk({name, "_sel"}, mem_sel, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_err"}, err, 0);
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    int wc0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    base_addr = '0; word_count = '0; in_data = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("idle");

    // 1: basic four-word image at 0
    beats = '{64'h22222222_11111111, 64'h44444444_33333333};
    expect_words(16'h0000, 4);
    chk("model_w0", exp_q[0], {16'h0000, 32'h11111111});
    chk("model_w3", exp_q[3], {16'h000C, 32'h44444444});
    do_start(16'h0000, 4);
    chk("t1_busy", busy, 1);
    chk("t1_cpu_rst_n", cpu_rst_n, 0);
    feed(2, -1, 0);
    wait_done("t1", 2);

    // 2: odd count, unaligned base; upper word of last beat dropped
    beats = '{64'hB0B0B0B0_A0A0A0A0, 64'hDEADDEAD_C0C0C0C0};
    expect_words(16'h0102, 3);
    wc0 = wr_count;
    do_start(16'h0102, 3);
    chk("t2_done_cleared", done, 0);
    feed(2, -1, 0);
    wait_done("t2", 1);
    chk("t2_last_addr", last_addr, 16'h0108);
    chk("t2_writes", wr_count - wc0, 3);

    // 3: range boundary
    beats = '{64'h87654321_12345678};
    chk("model_fit", model_range_err(16'hFFF8, 2), 0);
    expect_words(16'hFFF8, 2);
    chk("model_top", exp_q[1], {16'hFFFC, 32'h87654321});
    do_start(16'hFFF8, 2);
    feed(1, -1, 0);
    wait_done("t3a", 2);
    chk("model_over", model_range_err(16'hFFF8, 3), 1);
    wc0 = wr_count;
    do_start(16'hFFF8, 3);
    chk("t3_err", err, 1);
    chk("t3_cpu_rst_n", cpu_rst_n, 0);
    chk("t3_done", done, 0);
    chk("t3_sel", mem_sel, 0);
    repeat (4) @(negedge clk);
    chk("t3_err_held", err, 1);
    chk("t3_no_writes", wr_count - wc0, 0);

    // 4: backpressure mid-image, starting from ERR
    beats = '{64'h0000000B_0000000A, 64'h0000000D_0000000C,
              64'h0000000F_0000000E, 64'h00000011_00000010};
    expect_words(16'h0400, 8);
    do_start(16'h0400, 8);
    chk("t4_err_cleared", err, 0);
    feed(4, 2, 5);
    wait_done("t4", 2);

    // 5: abort during the high-word write of the second beat
    beats = '{64'h55550002_55550001, 64'h55550004_55550003,
              64'h55550006_55550005, 64'h55550008_55550007};
    expect_words(16'h0800, 4);
    do_start(16'h0800, 8);
    feed(2, -1, 0);
    @(negedge clk);
    abort = 1'b1;
    chk("t5_hi_wrt_en", mem_wrt_en, 1);
    chk("t5_hi_addr", mem_addr, 16'h080C);
    @(negedge clk);
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_err", err, 0);
    chk("t5_cpu_rst_n", cpu_rst_n, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_pending", exp_q.size(), 0);
    beats = '{64'h66660002_66660001, 64'h66660004_66660003};
    expect_words(16'h0800, 4);
    do_start(16'h0800, 4);
    feed(2, -1, 0);
    wait_done("t5b", 2);

    // 6: asynchronous reset while waiting for a beat, then empty image
    beats = '{64'h77770002_77770001, 64'h77770004_77770003};
    expect_words(16'h0200, 2);
    do_start(16'h0200, 4);
    feed(1, -1, 0);
    repeat (2) @(negedge clk);
    chk("t6_fill_ready", in_ready, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t6_async");
    chk("t6_pending", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wc0 = wr_count;
    do_start(16'h0300, 0);
    chk("t6_zero_done", done, 1);
    chk("t6_zero_cpu", cpu_rst_n, 1);
    repeat (3) @(negedge clk);
    chk("t6_zero_writes", wr_count - wc0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
